// File: rtl/rf_operand_fetch.sv
// Operand fetch controller in front of a 16x16 dual-read register file with one-cycle reads.
// Launches both reads on acceptance and holds forwarded operands until downstream consumes them.
module rf_operand_fetch #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 16,
    parameter logic [1:0]  REGW_WR = 2'b01,
    parameter logic [1:0]  REGW_RD = 2'b00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_sr1,
    input  logic [ADDR_W-1:0] in_sr2,
    input  logic [ADDR_W-1:0] in_dr,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_dr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [1:0]        rf_regw,
    output logic [ADDR_W-1:0] rf_dr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_sr1,
    output logic [ADDR_W-1:0] rf_sr2,
    input  logic [DATA_W-1:0] rf_sr1_data,
    input  logic [DATA_W-1:0] rf_sr2_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [ADDR_W-1:0] out_dr
);

    typedef enum logic [1:0] {StIdle, StRead, StHold} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   sr1_q, sr1_d, sr2_q, sr2_d, dr_q, dr_d;
    logic                fwd1_q, fwd1_d, fwd2_q, fwd2_d;
    logic [DATA_W-1:0]   fwd1_data_q, fwd1_data_d, fwd2_data_q, fwd2_data_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_op1_q, out_op1_d, out_op2_q, out_op2_d;
    logic [ADDR_W-1:0]   out_dr_q, out_dr_d;

    logic accept;
    logic hit1, hit2;

    assign in_ready = (state_q == StIdle) || ((state_q == StHold) && out_ready);
    assign accept   = in_valid && in_ready;

    // Write port is a pure pass-through; held inactive while in reset.
    assign rf_regw  = (rst_n && wb_valid) ? REGW_WR : REGW_RD;
    assign rf_dr    = wb_dr;
    assign rf_wdata = wb_data;

    // Present new addresses at the acceptance edge so data arrives one cycle later.
    assign rf_sr1 = in_ready ? in_sr1 : sr1_q;
    assign rf_sr2 = in_ready ? in_sr2 : sr2_q;

    assign hit1 = wb_valid && (wb_dr == sr1_q);
    assign hit2 = wb_valid && (wb_dr == sr2_q);

    assign out_valid = out_valid_q;
    assign out_op1   = out_op1_q;
    assign out_op2   = out_op2_q;
    assign out_dr    = out_dr_q;

    always_comb begin
        state_d     = state_q;
        sr1_d       = sr1_q;
        sr2_d       = sr2_q;
        dr_d        = dr_q;
        fwd1_d      = fwd1_q;
        fwd2_d      = fwd2_q;
        fwd1_data_d = fwd1_data_q;
        fwd2_data_d = fwd2_data_q;
        out_valid_d = out_valid_q;
        out_op1_d   = out_op1_q;
        out_op2_d   = out_op2_q;
        out_dr_d    = out_dr_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) state_d = StRead;
            end
            StRead: begin
                // Newest write wins, then the write seen at acceptance, then the file.
                out_op1_d   = hit1 ? wb_data : (fwd1_q ? fwd1_data_q : rf_sr1_data);
                out_op2_d   = hit2 ? wb_data : (fwd2_q ? fwd2_data_q : rf_sr2_data);
                out_dr_d    = dr_q;
                out_valid_d = 1'b1;
                state_d     = StHold;
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = in_valid ? StRead : StIdle;
                end else begin
                    if (hit1) out_op1_d = wb_data;
                    if (hit2) out_op2_d = wb_data;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            sr1_d       = in_sr1;
            sr2_d       = in_sr2;
            dr_d        = in_dr;
            // The file returns the pre-write value for a same-edge write.
            fwd1_d      = wb_valid && (wb_dr == in_sr1);
            fwd2_d      = wb_valid && (wb_dr == in_sr2);
            fwd1_data_d = wb_data;
            fwd2_data_d = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sr1_q       <= '0;
            sr2_q       <= '0;
            dr_q        <= '0;
            fwd1_q      <= 1'b0;
            fwd2_q      <= 1'b0;
            fwd1_data_q <= '0;
            fwd2_data_q <= '0;
            out_valid_q <= 1'b0;
            out_op1_q   <= '0;
            out_op2_q   <= '0;
            out_dr_q    <= '0;
        end else begin
            state_q     <= state_d;
            sr1_q       <= sr1_d;
            sr2_q       <= sr2_d;
            dr_q        <= dr_d;
            fwd1_q      <= fwd1_d;
            fwd2_q      <= fwd2_d;
            fwd1_data_q <= fwd1_data_d;
            fwd2_data_q <= fwd2_data_d;
            out_valid_q <= out_valid_d;
            out_op1_q   <= out_op1_d;
            out_op2_q   <= out_op2_d;
            out_dr_q    <= out_dr_d;
        end
    end

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Bench for rf_operand_fetch: behavioural register file, directed vector table, reset
// mid-request, and random traffic against an architectural-register reference model.
module tb_rf_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  in_sr1, in_sr2, in_dr;
    logic        wb_valid;
    logic [3:0]  wb_dr;
    logic [15:0] wb_data;
    logic [1:0]  rf_regw;
    logic [3:0]  rf_dr, rf_sr1, rf_sr2;
    logic [15:0] rf_wdata, rf_sr1_data, rf_sr2_data;
    logic        out_valid, out_ready;
    logic [15:0] out_op1, out_op2;
    logic [3:0]  out_dr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_operand_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sr1     (in_sr1),
        .in_sr2     (in_sr2),
        .in_dr      (in_dr),
        .wb_valid   (wb_valid),
        .wb_dr      (wb_dr),
        .wb_data    (wb_data),
        .rf_regw    (rf_regw),
        .rf_dr      (rf_dr),
        .rf_wdata   (rf_wdata),
        .rf_sr1     (rf_sr1),
        .rf_sr2     (rf_sr2),
        .rf_sr1_data(rf_sr1_data),
        .rf_sr2_data(rf_sr2_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op1    (out_op1),
        .out_op2    (out_op2),
        .out_dr     (out_dr)
    );

    // Register file: clocked reads return the pre-write value on a same-edge write.
    logic [15:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = '0;
    always @(posedge clk) begin
        rf_sr1_data <= mem[rf_sr1];
        rf_sr2_data <= mem[rf_sr2];
        if (rf_regw[0]) mem[rf_dr] <= rf_wdata;
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [3:0]  s1, s2, d;
        logic        wv;
        logic [3:0]  wdr;
        logic [15:0] wd;
        logic        ord;
        logic        e_ir;
        logic [1:0]  e_rw;
        logic        e_ov;
        logic [15:0] e_op1, e_op2;
        logic [3:0]  e_dr;
    } vec_t;

    function automatic vec_t v(logic iv, logic [3:0] s1, logic [3:0] s2, logic [3:0] d,
                               logic wv, logic [3:0] wdr, logic [15:0] wd, logic ord,
                               logic eir, logic [1:0] erw, logic eov,
                               logic [15:0] e1, logic [15:0] e2, logic [3:0] ed);
        vec_t r;
        r.iv = iv; r.s1 = s1; r.s2 = s2; r.d = d;
        r.wv = wv; r.wdr = wdr; r.wd = wd; r.ord = ord;
        r.e_ir = eir; r.e_rw = erw; r.e_ov = eov;
        r.e_op1 = e1; r.e_op2 = e2; r.e_dr = ed;
        return r;
    endfunction

    // Reference model: architectural register values plus the single outstanding request.
    logic [15:0] arch [16];
    bit          have_req;
    int          age;
    logic [3:0]  m_sr1, m_sr2, m_dr;

    task automatic run_cycle();
        bit exp_ir, exp_ov, acc, cons;
        #1;
        exp_ov = have_req && (age >= 1);
        exp_ir = !have_req || (exp_ov && out_ready);
        chk("in_ready", 16'(in_ready), 16'(exp_ir));
        chk("rf_regw", 16'(rf_regw), wb_valid ? 16'h1 : 16'h0);
        chk("out_valid", 16'(out_valid), 16'(exp_ov));
        if (exp_ov) begin
            chk("op1", out_op1, arch[m_sr1]);
            chk("op2", out_op2, arch[m_sr2]);
            chk("out_dr", 16'(out_dr), 16'(m_dr));
        end
        acc  = in_valid && exp_ir;
        cons = exp_ov && out_ready;
        @(posedge clk);
        if (wb_valid) arch[wb_dr] = wb_data;
        if (cons) have_req = 0;
        if (have_req) age++;
        if (acc) begin
            have_req = 1;
            age      = 0;
            m_sr1    = in_sr1;
            m_sr2    = in_sr2;
            m_dr     = in_dr;
        end
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    vec_t tbl [18];

    initial begin
        tbl[0]  = v(0, 0, 0, 0, 1, 3, 16'h1111, 1, 1, 2'b01, 0, 0, 0, 0);
        tbl[1]  = v(0, 0, 0, 0, 1, 5, 16'h2222, 1, 1, 2'b01, 0, 0, 0, 0);
        tbl[2]  = v(1, 3, 5, 7, 0, 0, 16'h0000, 1, 1, 2'b00, 0, 0, 0, 0);
        tbl[3]  = v(0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 2'b00, 0, 0, 0, 0);
        tbl[4]  = v(0, 0, 0, 0, 0, 0, 16'h0000, 1, 1, 2'b00, 1, 16'h1111, 16'h2222, 7);
        tbl[5]  = v(1, 3, 5, 1, 1, 3, 16'hAAAA, 1, 1, 2'b01, 0, 0, 0, 0);
        tbl[6]  = v(0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 2'b00, 0, 0, 0, 0);
        tbl[7]  = v(0, 0, 0, 0, 0, 0, 16'h0000, 1, 1, 2'b00, 1, 16'hAAAA, 16'h2222, 1);
        tbl[8]  = v(1, 3, 5, 2, 1, 5, 16'h9999, 1, 1, 2'b01, 0, 0, 0, 0);
        tbl[9]  = v(0, 0, 0, 0, 1, 5, 16'hBBBB, 1, 0, 2'b01, 0, 0, 0, 0);
        tbl[10] = v(1, 9, 9, 4, 1, 3, 16'hCCCC, 0, 0, 2'b01, 1, 16'hAAAA, 16'hBBBB, 2);
        tbl[11] = v(1, 9, 9, 4, 0, 0, 16'h0000, 0, 0, 2'b00, 1, 16'hCCCC, 16'hBBBB, 2);
        tbl[12] = v(1, 9, 9, 4, 0, 0, 16'h0000, 0, 0, 2'b00, 1, 16'hCCCC, 16'hBBBB, 2);
        tbl[13] = v(1, 9, 9, 4, 0, 0, 16'h0000, 0, 0, 2'b00, 1, 16'hCCCC, 16'hBBBB, 2);
        tbl[14] = v(1, 9, 9, 4, 1, 9, 16'h0F0F, 1, 1, 2'b01, 1, 16'hCCCC, 16'hBBBB, 2);
        tbl[15] = v(0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 2'b00, 0, 0, 0, 0);
        tbl[16] = v(0, 0, 0, 0, 0, 0, 16'h0000, 1, 1, 2'b00, 1, 16'h0F0F, 16'h0F0F, 4);
        tbl[17] = v(0, 0, 0, 0, 0, 0, 16'h0000, 1, 1, 2'b00, 0, 0, 0, 0);

        rst_n = 1'b0;
        in_valid = 0; in_sr1 = 0; in_sr2 = 0; in_dr = 0;
        wb_valid = 1; wb_dr = 4'd2; wb_data = 16'hDEAD; out_ready = 1;
        #3;
        chk("rst out_valid", 16'(out_valid), 16'h0);
        chk("rst op1", out_op1, 16'h0);
        chk("rst op2", out_op2, 16'h0);
        chk("rst out_dr", 16'(out_dr), 16'h0);
        chk("rst in_ready", 16'(in_ready), 16'h1);
        chk("rst rf_regw", 16'(rf_regw), 16'h0);
        wb_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            in_valid = tbl[i].iv; in_sr1 = tbl[i].s1; in_sr2 = tbl[i].s2; in_dr = tbl[i].d;
            wb_valid = tbl[i].wv; wb_dr = tbl[i].wdr; wb_data = tbl[i].wd;
            out_ready = tbl[i].ord;
            #1;
            chk($sformatf("v%0d in_ready", i), 16'(in_ready), 16'(tbl[i].e_ir));
            chk($sformatf("v%0d rf_regw", i), 16'(rf_regw), 16'(tbl[i].e_rw));
            chk($sformatf("v%0d out_valid", i), 16'(out_valid), 16'(tbl[i].e_ov));
            if (tbl[i].e_ov) begin
                chk($sformatf("v%0d op1", i), out_op1, tbl[i].e_op1);
                chk($sformatf("v%0d op2", i), out_op2, tbl[i].e_op2);
                chk($sformatf("v%0d out_dr", i), 16'(out_dr), 16'(tbl[i].e_dr));
            end
            @(posedge clk);
            @(negedge clk);
        end

        // Reset while a request is in its read cycle.
        in_valid = 1; in_sr1 = 3; in_sr2 = 5; in_dr = 6;
        wb_valid = 0; out_ready = 1;
        @(posedge clk);
        #2;
        in_valid = 0;
        wb_valid = 1; wb_dr = 3; wb_data = 16'h1234;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 16'(out_valid), 16'h0);
        chk("midrst op1", out_op1, 16'h0);
        chk("midrst op2", out_op2, 16'h0);
        chk("midrst out_dr", 16'(out_dr), 16'h0);
        chk("midrst rf_regw", 16'(rf_regw), 16'h0);
        @(negedge clk);
        wb_valid = 0;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("postrst in_ready", 16'(in_ready), 16'h1);
            chk("postrst out_valid", 16'(out_valid), 16'h0);
            @(negedge clk);
        end

        // Random traffic against the reference model, after a full preload.
        have_req = 0;
        age      = 0;
        m_sr1 = 0; m_sr2 = 0; m_dr = 0;
        for (int r = 0; r < 16; r++) begin
            in_valid = 0; out_ready = 1;
            wb_valid = 1; wb_dr = 4'(r); wb_data = 16'($urandom);
            run_cycle();
        end
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 99) < 65);
            in_sr1    = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3))
                                                     : 4'($urandom_range(0, 15));
            in_sr2    = ($urandom_range(0, 3) == 0) ? in_sr1 : 4'($urandom_range(0, 3));
            in_dr     = 4'($urandom_range(0, 15));
            wb_valid  = ($urandom_range(0, 1) != 0);
            wb_dr     = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 3))
                                                   : 4'($urandom_range(0, 15));
            wb_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 99) < 65);
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_operand_fetch.md
Name: rf_operand_fetch

Overview:
- Requester-side controller for the 16x16 dual-read, single-write register file (clocked reads, one-cycle read latency, write on `RegW[0]`).
- Accepts decoded operand requests with a valid/ready handshake and launches both reads, then returns forwarded, up-to-date operands downstream with a valid/ready handshake.
- Funnels writeback requests into the register-file write port.
- Sits between the decoder and the execute stage.

Parameters:
- ADDR_W, 4, register address width (16 registers)
- DATA_W, 16, register data width
- REGW_WR, 2'b01, RegW code driven for a write (WRITE_sv)
- REGW_RD, 2'b00, RegW code driven when not writing (READ)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request valid
- in_ready  out  1  request accepted when in_valid&in_ready at an edge
- in_sr1  in  ADDR_W  source register 1
- in_sr2  in  ADDR_W  source register 2
- in_dr  in  ADDR_W  destination tag, passed through
- wb_valid  in  1  writeback request, always accepted
- wb_dr  in  ADDR_W  writeback register
- wb_data  in  DATA_W  writeback value
- rf_regw  out  2  to register file RegW
- rf_dr  out  ADDR_W  to register file DR
- rf_wdata  out  DATA_W  to register file Write_data
- rf_sr1  out  ADDR_W  to register file SR1
- rf_sr2  out  ADDR_W  to register file SR2
- rf_sr1_data  in  DATA_W  from register file SR1_Data
- rf_sr2_data  in  DATA_W  from register file SR2_Data
- out_valid  out  1  operands valid
- out_ready  in  1  downstream consumes when out_valid&out_ready at an edge
- out_op1  out  DATA_W  operand 1
- out_op2  out  DATA_W  operand 2
- out_dr  out  ADDR_W  destination tag

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - out_valid=0; out_op1, out_op2, out_dr = 0.
  - Internal sr1_q, sr2_q, fwd flags = 0.
  - rf_regw forced to REGW_RD while rst_n low.
  - Register-file contents are not touched.
- Write path (combinational):
  - rf_regw = wb_valid ? REGW_WR : REGW_RD.
  - rf_dr = wb_dr; rf_wdata = wb_data.
  - The write lands at the same edge wb_valid is sampled.
- Read address: rf_sr1/rf_sr2 = in_ready ? in_sr1/in_sr2 : sr1_q/sr2_q. The register file therefore samples the addresses at the acceptance edge.
- States:
  - IDLE: in_ready=1. On accept → READ; capture sr1_q, sr2_q, dr_q.
  - READ: in_ready=0; lasts exactly one cycle. At the next edge, capture operands, set out_valid=1 → HOLD.
  - HOLD: in_ready=out_ready.
    - If out_ready and in_valid: consume, accept new request → READ, out_valid→0.
    - If out_ready and not in_valid: → IDLE, out_valid→0.
    - If not out_ready: stay; outputs stable except forwarding updates.
- Latency: accept at edge E0 → out_valid high after E1. Throughput is one request per 2 cycles.
- Forwarding (per operand; shown for op1, op2 identical):
  - At the acceptance edge E0, if wb_valid && wb_dr==in_sr1: set fwd1=1, fwd1_data=wb_data. The register file returns the pre-write value here, so the stale read must be overridden; otherwise fwd1=0.
  - At E1, out_op1 takes the first matching source:
    1. wb_data if wb_valid && wb_dr==sr1_q (newest)
    2. fwd1_data if fwd1
    3. rf_sr1_data
  - In HOLD, each edge with wb_valid && wb_dr==sr1_q overwrites out_op1 with wb_data. Held operands never go stale.
- sr1==sr2 with a matching write: both operands are forwarded identically.
- Writebacks are never stalled and are independent of state.
- Reset mid-READ/HOLD: the request is dropped with no output pulse. After release the block waits in IDLE.

Test Plan:
- Basic read: preload R3=0x1111, R5=0x2222 via wb. Request sr1=3, sr2=5, dr=7 with out_ready=1 → out_valid one cycle after accept; op1=0x1111, op2=0x2222, out_dr=7.
- Same-edge hazard: wb R3=0xAAAA in the same cycle as accepting sr1=3 → op1=0xAAAA, not the old 0x1111.
- READ-cycle hazard: wb R5=0xBBBB the cycle after accept, with an earlier same-edge wb R5=0x9999 → op2=0xBBBB (newest wins).
- Backpressure: out_ready=0 for 4 cycles with wb R3=0xCCCC during HOLD → out_op1 updates to 0xCCCC, out_valid stays 1, in_ready=0. Releasing out_ready while in_valid is high accepts the next request at that same edge.
- sr1=sr2=9 with a same-edge wb R9=0x0F0F → op1=op2=0x0F0F. Separately, rf_regw=01 exactly in cycles where wb_valid=1, otherwise 00.
- Reset in READ: assert rst_n low mid-cycle → out_valid=0, ops=0 immediately, rf_regw=00. After release, in_ready=1 and no stray output.
